i2c_cmd_tx: RTL and testbench

- I2C write-only master for the clock-control chip; the transmit end of the slowdown/speedup requests raised by the POST counter.
- Each request sends one fixed 3-byte write: START, DEV_ADDR+W, REG_ADDR, data byte, STOP.
- The data byte is SLOW_DATA or FAST_DATA, selected by the request type.
- One-deep pending slot, so a speedup raised during a slowdown transfer is not lost.

---
 rtl/i2c_cmd_tx_if.sv | 27 ++
 rtl/i2c_cmd_tx.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_cmd_tx.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : i2c_cmd_tx_if
// Brief   : Request inputs, I2C line controls and status of the command master.
// Revision: 1.0 - initial release
// ============================================================================
interface i2c_cmd_tx_if;
  logic send_slow;
  logic send_fast;
  logic sda_i;
  logic scl_o;
  logic sda_o;
  logic busy;
  logic done;
  logic nack;

  modport master (
    input  send_slow, send_fast, sda_i,
    output scl_o, sda_o, busy, done, nack
  );

  modport slave (
    output send_slow, send_fast, sda_i,
    input  scl_o, sda_o, busy, done, nack
  );
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module  : i2c_cmd_tx
// Brief   : Write-only I2C master sending a fixed 3-byte slow/fast clock command.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_cmd_tx #(
  parameter int         CLK_DIV   = 120,
  parameter logic [6:0] DEV_ADDR  = 7'h70,
  parameter logic [7:0] REG_ADDR  = 8'hCD,
  parameter logic [7:0] SLOW_DATA = 8'h04,
  parameter logic [7:0] FAST_DATA = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  i2c_cmd_tx_if.master   bus
);

  localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]         c_BIT_LAST = 5'd26;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_DIV_W-1:0] r_div, w_div_nxt;
  logic [1:0]         r_qtr, w_qtr_nxt;
  logic [4:0]         r_bit, w_bit_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_pend_vld, w_pend_vld_nxt;
  logic [7:0]         r_pend_data, w_pend_data_nxt;
  logic               r_nack, w_nack_nxt;
  logic               r_slow_q, r_fast_q;
  logic               r_slow_arm, r_fast_arm;

  logic               w_req_slow, w_req_fast, w_req;
  logic [7:0]         w_req_data;
  logic               w_qtr_end;
  logic               w_ack_slot;
  logic [26:0]        w_frame;
  logic               w_bit_val;
  logic               w_scl, w_sda;

  // An input must be seen low after reset before its rising edge counts,
  // so a level held across reset cannot fire a spurious request.
  assign w_req_fast = bus.send_fast & ~r_fast_q & r_fast_arm;
  assign w_req_slow = bus.send_slow & ~r_slow_q & r_slow_arm;
  assign w_req      = w_req_fast | w_req_slow;
  assign w_req_data = w_req_fast ? FAST_DATA : SLOW_DATA;

  assign w_qtr_end  = (r_div == c_DIV_LAST);
  assign w_ack_slot = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);
  assign w_frame    = {DEV_ADDR, 1'b0, 1'b1, REG_ADDR, 1'b1, r_data, 1'b1};
  assign w_bit_val  = w_frame[c_BIT_LAST - r_bit];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_qtr       <= '0;
      r_bit       <= '0;
      r_data      <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_nack      <= 1'b0;
      r_slow_q    <= 1'b0;
      r_fast_q    <= 1'b0;
      r_slow_arm  <= 1'b0;
      r_fast_arm  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_qtr       <= w_qtr_nxt;
      r_bit       <= w_bit_nxt;
      r_data      <= w_data_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_nack      <= w_nack_nxt;
      r_slow_q    <= bus.send_slow;
      r_fast_q    <= bus.send_fast;
      r_slow_arm  <= r_slow_arm | ~bus.send_slow;
      r_fast_arm  <= r_fast_arm | ~bus.send_fast;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = w_qtr_end ? '0 : r_div + c_DIV_W'(1);
    w_qtr_nxt       = r_qtr;
    w_bit_nxt       = r_bit;
    w_data_nxt      = r_data;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_data_nxt = r_pend_data;
    w_nack_nxt      = r_nack;

    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        w_qtr_nxt = '0;
        w_bit_nxt = '0;
        if (w_req) begin
          w_data_nxt  = w_req_data;
          w_nack_nxt  = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_qtr_end) begin
          if (r_qtr == 2'd1) begin
            w_qtr_nxt   = '0;
            w_bit_nxt   = '0;
            w_state_nxt = S_BIT;
          end else begin
            w_qtr_nxt = r_qtr + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (w_qtr_end && (r_qtr == 2'd2) && w_ack_slot && bus.sda_i) begin
          w_nack_nxt = 1'b1;
        end
        if (w_qtr_end) begin
          w_qtr_nxt = r_qtr + 2'd1;
          if (r_qtr == 2'd3) begin
            // r_nack only reflects the current transfer: it clears at start.
            if ((w_ack_slot && r_nack) || (r_bit == c_BIT_LAST)) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit + 5'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (w_qtr_end) begin
          w_qtr_nxt = r_qtr + 2'd1;
          if (r_qtr == 2'd3) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_div_nxt = '0;
        w_qtr_nxt = '0;
        w_bit_nxt = '0;
        if (r_pend_vld) begin
          w_data_nxt     = r_pend_data;
          w_pend_vld_nxt = 1'b0;
          w_nack_nxt     = 1'b0;
          w_state_nxt    = S_START;
        end else if (w_req) begin
          w_data_nxt  = w_req_data;
          w_nack_nxt  = 1'b0;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Requests that cannot start now park in the single pending slot.
    if (w_req && (r_state != S_IDLE) && !((r_state == S_DONE) && !r_pend_vld)) begin
      w_pend_vld_nxt  = 1'b1;
      w_pend_data_nxt = w_req_data;
    end
  end

  always_comb begin
    w_scl = 1'b1;
    w_sda = 1'b1;
    case (r_state)
      S_START: begin
        w_sda = (r_qtr == 2'd0);
      end
      S_BIT: begin
        w_scl = r_qtr[1];
        w_sda = w_ack_slot ? 1'b1 : w_bit_val;
      end
      S_STOP: begin
        w_scl = r_qtr[1];
        w_sda = (r_qtr == 2'd3);
      end
      default: begin
        w_scl = 1'b1;
        w_sda = 1'b1;
      end
    endcase
  end

  assign bus.scl_o = w_scl;
  assign bus.sda_o = w_sda;
  assign bus.busy  = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_STOP);
  assign bus.done  = (r_state == S_DONE);
  assign bus.nack  = r_nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_cmd_tx
// Brief   : Self-checking bench: bus decoder, ACK/NACK slave and transfer model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_tx;

  localparam int         CLK_DIV   = 2;
  localparam logic [6:0] DEV_ADDR  = 7'h70;
  localparam logic [7:0] REG_ADDR  = 8'hCD;
  localparam logic [7:0] SLOW_DATA = 8'h04;
  localparam logic [7:0] FAST_DATA = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_cmd_tx_if bus ();

  i2c_cmd_tx #(
    .CLK_DIV  (CLK_DIV),
    .DEV_ADDR (DEV_ADDR),
    .REG_ADDR (REG_ADDR),
    .SLOW_DATA(SLOW_DATA),
    .FAST_DATA(FAST_DATA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Bus observer state
  int          cyc = 0;
  int          dones = 0;
  int          busy_gap = 0;
  int          dbl_done = 0;
  int          nack_byte = -1;
  int          nbits = 0;
  int          n_start = 0;
  int          n_stop = 0;
  int          start_cyc = 0;
  logic [31:0] bits = '0;
  bit          in_xfer = 1'b0;
  logic        p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0, p_done = 1'b0;

  int          q_nb[$];
  logic [31:0] q_bits[$];
  int          q_lat[$];
  int          q_ss[$];

  // Decodes SCL/SDA into START/bits/STOP and plays the slave's ACK/NACK.
  initial begin
    bus.sda_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_xfer = 1'b0; nbits = 0; bits = '0;
        p_scl = 1'b1; p_sda = 1'b1; p_busy = 1'b0; p_done = 1'b0;
        bus.sda_i = 1'b0;
      end else begin
        if (bus.busy && !p_busy) begin
          in_xfer = 1'b1; start_cyc = cyc; n_start = 0; n_stop = 0;
        end
        if (p_scl && bus.scl_o && p_sda && !bus.sda_o) begin
          n_start++; nbits = 0; bits = '0;
        end
        if (!p_scl && bus.scl_o) begin
          bits = {bits[30:0], bus.sda_o};
          nbits++;
          bus.sda_i = (nack_byte >= 0 && nbits == 9 * (nack_byte + 1)) ? 1'b1 : 1'b0;
        end
        if (p_scl && bus.scl_o && !p_sda && bus.sda_o) n_stop++;
        if (bus.done && p_done) dbl_done++;
        if (bus.done) begin
          // The final SCL rise belongs to STOP, not to a data bit.
          q_nb.push_back(nbits - 1);
          q_bits.push_back(bits >> 1);
          q_lat.push_back(cyc - start_cyc);
          q_ss.push_back(n_start * 16 + n_stop);
          in_xfer = 1'b0;
          dones++;
        end else if (in_xfer && !bus.busy) begin
          busy_gap++;
        end
        p_scl = bus.scl_o; p_sda = bus.sda_o; p_busy = bus.busy; p_done = bus.done;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int n;
    n = budget;
    while (dones < target && n > 0) begin
      tick();
      n--;
    end
    check({tag, "_done_count"}, 32'(dones), 32'(target));
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int n;
    n = budget;
    while (!bus.busy && n > 0) begin
      tick();
      n--;
    end
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  function automatic logic [7:0] dec_byte(input logic [31:0] b, input int nb, input int k);
    logic [31:0] t;
    if (nb < 9 * k + 8) return 8'h00;
    t = b >> (nb - 9 * k - 8);
    return t[7:0];
  endfunction

  // Model: bytes sent stop after the NACKed one; each byte costs 9 bits of 4 quarters.
  task automatic check_xfer(input string tag, input int nbytes, input logic [7:0] data);
    logic [7:0]  exp_b[3];
    int          nb, lat, ss;
    logic [31:0] b;
    exp_b[0] = {DEV_ADDR, 1'b0};
    exp_b[1] = REG_ADDR;
    exp_b[2] = data;
    check({tag, "_recorded"}, 32'(q_nb.size() > 0), 32'd1);
    if (q_nb.size() > 0) begin
      nb = q_nb.pop_front(); b = q_bits.pop_front();
      lat = q_lat.pop_front(); ss = q_ss.pop_front();
      check({tag, "_nbits"}, 32'(nb), 32'(9 * nbytes));
      for (int k = 0; k < nbytes; k++)
        check($sformatf("%s_byte%0d", tag, k), 32'(dec_byte(b, nb, k)), 32'(exp_b[k]));
      check({tag, "_latency"}, 32'(lat), 32'((2 + 36 * nbytes + 4) * CLK_DIV));
      check({tag, "_start_stop"}, 32'(ss), 32'h11);
    end
  endtask

  int base;
  logic [7:0] rdata;
  int rnack, rgap;
  bit rfast;

  initial begin
    bus.send_slow = 1'b0;
    bus.send_fast = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_scl", 32'(bus.scl_o), 32'd1);
    check("rst_sda", 32'(bus.sda_o), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_nack", 32'(bus.nack), 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Single slowdown, all ACKed
    base = dones;
    bus.send_slow = 1'b1;
    wait_busy(10, "slow");
    bus.send_slow = 1'b0;
    wait_dones(base + 1, 400, "slow");
    check_xfer("slow", 3, SLOW_DATA);
    check("slow_nack", 32'(bus.nack), 32'd0);
    check("slow_busy_gap", 32'(busy_gap), 32'd0);

    // Speedup raised at bit 10 of a slowdown lands in the pending slot
    repeat (3) tick();
    base = dones;
    bus.send_slow = 1'b1;
    wait_busy(10, "pend");
    repeat (84) tick();
    bus.send_slow = 1'b0;
    bus.send_fast = 1'b1;
    repeat (2) tick();
    bus.send_fast = 1'b0;
    wait_dones(base + 2, 800, "pend");
    check_xfer("pend_first", 3, SLOW_DATA);
    check_xfer("pend_second", 3, FAST_DATA);

    // Simultaneous rise: fast wins, slow dropped
    repeat (3) tick();
    base = dones;
    bus.send_slow = 1'b1;
    bus.send_fast = 1'b1;
    wait_busy(10, "both");
    wait_dones(base + 1, 400, "both");
    repeat (300) tick();
    check("both_single", 32'(dones), 32'(base + 1));
    check_xfer("both", 3, FAST_DATA);
    bus.send_slow = 1'b0;
    bus.send_fast = 1'b0;

    // Address byte NACKed
    repeat (3) tick();
    base = dones;
    nack_byte = 0;
    bus.send_slow = 1'b1;
    wait_busy(10, "nack");
    bus.send_slow = 1'b0;
    wait_dones(base + 1, 400, "nack");
    check_xfer("nack", 1, SLOW_DATA);
    check("nack_sticky", 32'(bus.nack), 32'd1);
    nack_byte = -1;
    repeat (3) tick();
    check("nack_held_idle", 32'(bus.nack), 32'd1);
    base = dones;
    bus.send_fast = 1'b1;
    wait_busy(10, "nack_clr");
    check("nack_cleared", 32'(bus.nack), 32'd0);
    bus.send_fast = 1'b0;
    wait_dones(base + 1, 400, "nack_clr");
    check_xfer("nack_clr", 3, FAST_DATA);

    // Reset mid byte 2 with a speedup pending; held levels must not retrigger
    repeat (3) tick();
    base = dones;
    bus.send_slow = 1'b1;
    wait_busy(10, "rstmid");
    repeat (50) tick();
    bus.send_fast = 1'b1;
    repeat (58) tick();
    rst = 1'b1;
    tick();
    check("rstmid_scl", 32'(bus.scl_o), 32'd1);
    check("rstmid_sda", 32'(bus.sda_o), 32'd1);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    repeat (600) tick();
    check("rstmid_no_retrigger", 32'(dones), 32'(base));
    check("rstmid_idle", 32'(bus.busy), 32'd0);
    bus.send_slow = 1'b0;
    bus.send_fast = 1'b0;
    repeat (3) tick();
    bus.send_slow = 1'b1;
    wait_busy(10, "rstmid_again");
    bus.send_slow = 1'b0;
    wait_dones(base + 1, 400, "rstmid_again");
    check_xfer("rstmid_again", 3, SLOW_DATA);

    // Level held for 1000 clocks gives exactly one transfer
    repeat (3) tick();
    base = dones;
    bus.send_slow = 1'b1;
    repeat (1000) tick();
    bus.send_slow = 1'b0;
    check("held_one_xfer", 32'(dones), 32'(base + 1));
    check_xfer("held", 3, SLOW_DATA);

    // Randomized requests and NACK positions
    for (int i = 0; i < 6; i++) begin
      rfast = 1'($urandom_range(0, 1));
      rnack = int'($urandom_range(0, 3));
      rgap  = int'($urandom_range(1, 20));
      nack_byte = (rnack == 3) ? -1 : rnack;
      rdata = rfast ? FAST_DATA : SLOW_DATA;
      repeat (rgap) tick();
      base = dones;
      if (rfast) bus.send_fast = 1'b1; else bus.send_slow = 1'b1;
      repeat (int'($urandom_range(1, 4))) tick();
      bus.send_fast = 1'b0;
      bus.send_slow = 1'b0;
      wait_dones(base + 1, 400, $sformatf("rnd%0d", i));
      check_xfer($sformatf("rnd%0d", i), (rnack == 3) ? 3 : rnack + 1, rdata);
      check($sformatf("rnd%0d_nack", i), 32'(bus.nack), 32'(rnack != 3));
    end
    nack_byte = -1;

    check("busy_gap_total", 32'(busy_gap), 32'd0);
    check("done_single_cycle", 32'(dbl_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
